conv_mac_accum: RTL and testbench



---
 rtl/mnist_cnn_pkg.sv | 17 +
 rtl/conv_mac_accum_act_sat.sv | 53 +++++
 rtl/conv_mac_accum.sv | 149 ++++++++++++++
 tb/tb_conv_mac_accum.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mnist_cnn_pkg.sv
// Shared MNIST CNN definitions: data widths, activation limits and the
// window-stage state encoding used by the conv, pooling and dense stages.
package mnist_cnn_pkg;

  localparam int unsigned PROD_W = 15;
  localparam int unsigned OUT_W  = 8;

  localparam logic [OUT_W-1:0] ACT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] ACT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } mac_state_e;

endpackage

// File: rtl/conv_mac_accum_act_sat.sv
// act_sat: combinational signed IN_W -> OUT_W saturation.
// Build macro CONV_MAC_RELU_EN: clamp negative sums to 0 before saturating.
module act_sat #(
  parameter int unsigned IN_W  = 21,
  parameter int unsigned OUT_W = 8
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout_c
);

  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};

  logic sign;
  logic hi_zeros;

  // Value fits in OUT_W signed iff bits [IN_W-1:OUT_W-1] are all equal
  always_comb begin
    sign     = din[IN_W-1];
    hi_zeros = ~|din[IN_W-1:OUT_W-1];
  end

`ifdef CONV_MAC_RELU_EN
  // ReLU then saturate high; result range 0..SAT_MAX
  always_comb begin
    dout_c = din[OUT_W-1:0];
    if (sign) begin
      dout_c = '0;
    end else if (!hi_zeros) begin
      dout_c = SAT_MAX;
    end
  end
`else
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic hi_ones;

  // Upper-bit all-ones test for the negative range check
  always_comb begin
    hi_ones = &din[IN_W-1:OUT_W-1];
  end

  // Symmetric signed saturation
  always_comb begin
    dout_c = din[OUT_W-1:0];
    if (!sign && !hi_zeros) begin
      dout_c = SAT_MAX;
    end else if (sign && !hi_ones) begin
      dout_c = SAT_MIN;
    end
  end
`endif

endmodule

// File: rtl/conv_mac_accum.sv
// conv_mac_accum: accumulates KERNEL_N signed products plus a bias per
// kernel window and emits one saturated activation, held until consumed.
// Build macro CONV_MAC_RELU_EN: apply ReLU ahead of output saturation.
module conv_mac_accum #(
  parameter int unsigned PROD_W   = mnist_cnn_pkg::PROD_W,
  parameter int unsigned KERNEL_N = 25,
  parameter int unsigned ACC_W    = 21,
  parameter int unsigned OUT_W    = mnist_cnn_pkg::OUT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] in_data,
  input  logic [PROD_W-1:0] bias,
  output logic              in_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  input  logic              out_ready,
  output logic              overrun
);

  import mnist_cnn_pkg::*;

  localparam int unsigned CNT_W = 8;

  // Elaboration-time parameter legality
  if (KERNEL_N < 1 || KERNEL_N > 255) begin : g_bad_kernel
    $error("conv_mac_accum: KERNEL_N must be in 1..255");
  end
  if (ACC_W < PROD_W + $clog2(KERNEL_N + 1)) begin : g_bad_acc
    $error("conv_mac_accum: ACC_W too narrow for KERNEL_N products");
  end
  if (ACC_W <= OUT_W) begin : g_bad_out
    $error("conv_mac_accum: ACC_W must exceed OUT_W");
  end

  mac_state_e         state, state_n;
  logic [ACC_W-1:0]   acc, acc_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               out_valid_n;
  logic [OUT_W-1:0]   out_data_n;
  logic               overrun_n;
  logic               in_ready_n;

  logic [ACC_W-1:0]   data_sx_c;
  logic [ACC_W-1:0]   sum_c;
  logic [OUT_W-1:0]   sat_c;

  // Next accumulator value for an accepted beat; IDLE seeds with the bias
  always_comb begin
    data_sx_c = {{(ACC_W-PROD_W){in_data[PROD_W-1]}}, in_data};
    if (state == ST_IDLE) begin
      sum_c = {{(ACC_W-PROD_W){bias[PROD_W-1]}}, bias} + data_sx_c;
    end else begin
      sum_c = acc + data_sx_c;
    end
  end

  act_sat #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W)
  ) u_act_sat (
    .din    (sum_c),
    .dout_c (sat_c)
  );

  // State register and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      overrun   <= overrun_n;
      in_ready  <= in_ready_n;
    end
  end

  // Next-state and output logic; clear overrides everything
  always_comb begin
    state_n     = state;
    acc_n       = acc;
    cnt_n       = cnt;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    overrun_n   = overrun;

    if (clear) begin
      state_n     = ST_IDLE;
      acc_n       = '0;
      cnt_n       = '0;
      out_valid_n = 1'b0;
      overrun_n   = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            acc_n = sum_c;
            cnt_n = CNT_W'(1);
            if (KERNEL_N == 1) begin
              state_n     = ST_HOLD;
              out_valid_n = 1'b1;
              out_data_n  = sat_c;
            end else begin
              state_n = ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            acc_n = sum_c;
            cnt_n = cnt + CNT_W'(1);
            if (cnt == CNT_W'(KERNEL_N - 1)) begin
              state_n     = ST_HOLD;
              out_valid_n = 1'b1;
              out_data_n  = sat_c;
            end
          end
        end
        ST_HOLD: begin
          if (in_valid) begin
            overrun_n = 1'b1;
          end
          if (out_ready) begin
            state_n     = ST_IDLE;
            out_valid_n = 1'b0;
            cnt_n       = '0;
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end

    in_ready_n = (state_n != ST_HOLD);
  end

endmodule

// File: tb/tb_conv_mac_accum.sv
// Directed self-checking bench for conv_mac_accum (KERNEL_N=25, OUT_W=8).
// Honours CONV_MAC_RELU_EN for expected negative results.
module tb_conv_mac_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic [14:0] in_data;
  logic [14:0] bias;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  conv_mac_accum dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .bias      (bias),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Independent reference saturation on an integer sum
  function automatic logic [7:0] sat_ref(input int s);
    int v;
    v = s;
`ifdef CONV_MAC_RELU_EN
    if (v < 0) v = 0;
`endif
    if (v > 127) return 8'd127;
    if (v < -128) return 8'h80;
    return 8'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int d, input int b);
    in_valid = 1'b1;
    in_data  = 15'(d);
    bias     = 15'(b);
    step();
    in_valid = 1'b0;
  endtask

  task automatic beats(input int n, input int d, input int b);
    for (int i = 0; i < n; i++) beat(d, b);
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; bias = '0; out_ready = 1'b0;
    repeat (2) step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    beats(24, 4, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
    beat(4, 0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 8'd100) begin bad++; $display("FAIL basic_data got=%0d exp=100", out_data); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_hold_ready got=%b exp=0", in_ready); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_taken got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_idle_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_saturate();
    logic [7:0] exp_neg;
    exp_neg = sat_ref(-2500);
    beats(25, 100, 10);
    total++; if (out_data !== 8'd127) begin bad++; $display("FAIL sat_high got=%h exp=7f", out_data); end
    step();
    beats(25, -100, 0);
    total++; if (out_valid !== 1'b1 || out_data !== exp_neg) begin
      bad++; $display("FAIL sat_low got=%b/%h exp=1/%h", out_valid, out_data, exp_neg);
    end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    beats(25, 2, 0);
    total++; if (out_data !== 8'd50) begin bad++; $display("FAIL bp_data got=%0d exp=50", out_data); end
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin in_valid = 1'b1; in_data = 15'(50); end
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || out_data !== 8'd50 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_stable cyc=%0d got=%b/%0d/%b exp=1/50/0", c, out_valid, out_data, in_ready);
      end
    end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun got=%b exp=1", overrun); end
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", out_valid); end
    beats(25, 1, 0);
    total++; if (out_data !== 8'd25) begin bad++; $display("FAIL bp_next_window got=%0d exp=25", out_data); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL bp_sticky got=%b exp=1", overrun); end
    step();
  endtask

  task automatic test_clear();
    beats(12, 3, 0);
    clear = 1'b1; in_valid = 1'b1; in_data = 15'(9);
    step();
    clear = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || overrun !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL clear_state got=%b/%b/%b exp=0/0/1", out_valid, overrun, in_ready);
    end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clear_no_output got=%b exp=0", out_valid); end
    beats(25, 1, -5);
    total++; if (out_valid !== 1'b1 || out_data !== 8'd20) begin
      bad++; $display("FAIL clear_fresh got=%b/%0d exp=1/20", out_valid, out_data);
    end
    step();
  endtask

  task automatic test_async_reset();
    logic [7:0] exp_v;
    exp_v = sat_ref(7 - 75);
    beats(10, 5, 0);
    @(posedge clk);
    #3 reset = 1'b1;
    #2;
    total++; if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1 || overrun !== 1'b0) begin
      bad++; $display("FAIL async_reset got=%b/%h/%b/%b exp=0/00/1/0", out_valid, out_data, in_ready, overrun);
    end
    #2 reset = 1'b0;
    step();
    beats(24, -3, 7);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_early got=%b exp=0", out_valid); end
    beat(-3, 7);
    total++; if (out_valid !== 1'b1 || out_data !== exp_v) begin
      bad++; $display("FAIL async_window got=%b/%h exp=1/%h", out_valid, out_data, exp_v);
    end
    step();
  endtask

  task automatic test_random_gaps();
    int sum, d, b, g, pulses;
    logic [7:0] exp_v;
    for (int w = 0; w < 2; w++) begin
      b = (w == 0) ? -20 : 300;
      sum = b;
      pulses = 0;
      for (int i = 0; i < 25; i++) begin
        if (w == 0) d = int'($urandom_range(0, 16)) - 8;
        else        d = int'($urandom_range(0, 800)) - 400;
        sum += d;
        beat(d, b);
        if (out_valid) pulses++;
        if (i < 24) begin
          g = int'($urandom_range(0, 3));
          repeat (g) begin
            step();
            if (out_valid) pulses++;
          end
        end
      end
      exp_v = sat_ref(sum);
      total++; if (out_data !== exp_v) begin
        bad++; $display("FAIL rand_sum win=%0d got=%h exp=%h sum=%0d", w, out_data, exp_v, sum);
      end
      step();
      if (out_valid) pulses++;
      total++; if (pulses != 1) begin bad++; $display("FAIL rand_pulses win=%0d got=%0d exp=1", w, pulses); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_random_gaps();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
